fetch_stage_2stage: RTL and testbench

- Instruction-fetch stage of the two-stage pipeline; the consumer end of the hazard unit's fetch-side control.
- Holds the PC, issues instruction-memory reads, and reports i_ram_busy and iren back to the hazard unit.
- Obeys pc_en, npc_sel, if_ex_stall and if_ex_flush, and drives the IF/EX pipeline latch feeding execute.
- Includes a one-entry hold buffer so an instruction returned during an IF/EX stall is never lost.

---
 rtl/fetch_stage_2stage_if.sv | 66 ++++++
 rtl/fetch_stage_2stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage_2stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_2stage_if.sv
// Fetch-stage bundle: hazard-unit control, instruction-memory port and IF/EX latch outputs.
// FETCH_MISALIGN_CHECK_EN adds the fetch_misaligned flag.
interface fetch_stage_2stage_if;
  logic        pc_en;
  logic        npc_sel;
  logic        if_ex_stall;
  logic        if_ex_flush;
  logic [31:0] brj_addr;
  logic        i_ram_busy;
  logic        iren;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic [31:0] imem_rdata;
  logic        imem_busy;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc4;
  logic        fetch_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  // Seen from the fetch stage.
  modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
    output fetch_misaligned,
`endif
    input  pc_en,
    input  npc_sel,
    input  if_ex_stall,
    input  if_ex_flush,
    input  brj_addr,
    output i_ram_busy,
    output iren,
    output imem_addr,
    output imem_ren,
    input  imem_rdata,
    input  imem_busy,
    output fetch_instr,
    output fetch_pc,
    output fetch_pc4,
    output fetch_valid
  );

  // Seen from the hazard unit / memory / execute side.
  modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
    input  fetch_misaligned,
`endif
    output pc_en,
    output npc_sel,
    output if_ex_stall,
    output if_ex_flush,
    output brj_addr,
    input  i_ram_busy,
    input  iren,
    input  imem_addr,
    input  imem_ren,
    output imem_rdata,
    output imem_busy,
    input  fetch_instr,
    input  fetch_pc,
    input  fetch_pc4,
    input  fetch_valid
  );
endinterface

// File: rtl/fetch_stage_2stage.sv
// Instruction fetch stage: PC, imem request, one-entry hold buffer and IF/EX latch.
// Optional FETCH_MISALIGN_CHECK_EN suppresses reads from misaligned PCs and flags them.
module fetch_stage_2stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0200,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                CLK,
  input logic                RST,
  fetch_stage_2stage_if.slave bus
);

  localparam logic [1:0] RST_WAIT = 2'd0;
  localparam logic [1:0] FETCH    = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr_q, instr_d;
  logic [31:0] lpc_q, lpc_d;
  logic [31:0] lpc4_q, lpc4_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        pc_ok;
  logic        ren;
  logic        complete;
  logic        mis_fetch;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign pc_ok = (pc_q[1:0] == 2'b00);
  assign bus.fetch_misaligned = mis_q;
`else
  assign pc_ok = 1'b1;
`endif

  assign ren       = (state_q == FETCH) && pc_ok;
  assign mis_fetch = (state_q == FETCH) && !pc_ok;
  assign complete  = ren && !bus.imem_busy;
  assign pc_plus4  = pc_q + 32'd4;

  assign bus.imem_ren    = ren;
  assign bus.iren        = ren;
  assign bus.i_ram_busy  = ren & bus.imem_busy;
  assign bus.imem_addr   = pc_q;
  assign bus.fetch_instr = instr_q;
  assign bus.fetch_pc    = lpc_q;
  assign bus.fetch_pc4   = lpc4_q;
  assign bus.fetch_valid = valid_q;

  always_comb begin
    pc_d = pc_q;
    if (bus.pc_en) begin
      pc_d = bus.npc_sel ? bus.brj_addr : pc_plus4;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST_WAIT: state_d = FETCH;
      FETCH: begin
        if (!bus.if_ex_flush && bus.if_ex_stall && complete) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Either a flush discards the buffer or an unstalled cycle drains it.
        if (bus.if_ex_flush || !bus.if_ex_stall) begin
          state_d = FETCH;
        end
      end
      default: state_d = RST_WAIT;
    endcase
  end

  always_comb begin
    instr_d      = instr_q;
    lpc_d        = lpc_q;
    lpc4_d       = lpc4_q;
    valid_d      = valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_d        = mis_q;
`endif
    if (bus.if_ex_flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_d   = 1'b0;
`endif
    end else if (bus.if_ex_stall) begin
      if (complete) begin
        hold_instr_d = bus.imem_rdata;
        hold_pc_d    = pc_q;
      end
    end else if (state_q == HOLD) begin
      instr_d = hold_instr_q;
      lpc_d   = hold_pc_q;
      lpc4_d  = hold_pc_q + 32'd4;
      valid_d = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_d   = 1'b0;
`endif
    end else if (complete) begin
      instr_d = bus.imem_rdata;
      lpc_d   = pc_q;
      lpc4_d  = pc_plus4;
      valid_d = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_d   = 1'b0;
`endif
    end else if (mis_fetch) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      lpc_d   = pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_d   = 1'b1;
`endif
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RST_WAIT;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      lpc_q        <= 32'd0;
      lpc4_q       <= 32'd0;
      valid_q      <= 1'b0;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= 32'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      lpc_q        <= lpc_d;
      lpc4_q       <= lpc4_d;
      valid_q      <= valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q        <= mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage_2stage.sv
// Directed bench for fetch_stage_2stage: queue-based behavioural model checked every cycle,
// plus literal expectations; covers FETCH_MISALIGN_CHECK_EN when that macro is defined.
module tb_fetch_stage_2stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  fetch_stage_2stage_if bus ();

  fetch_stage_2stage #(
    .RESET_PC (32'h0000_0200),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Model: pending buffer as a queue; a request is outstanding once started with nothing buffered.
  logic [31:0] m_pc, m_instr, m_fpc, m_fpc4;
  logic        m_valid, m_mis, started;
  ent_t        buf_q[$];

  function automatic logic m_req();
    return started && (buf_q.size() == 0) && (!MIS || (m_pc[1:0] == 2'b00));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(posedge CLK) begin : model
    logic done;
    ent_t e;
    done = m_req() && !bus.imem_busy;
    if (RST) begin
      m_pc = 32'h200; m_instr = NOP; m_fpc = 0; m_fpc4 = 0;
      m_valid = 0; m_mis = 0; started = 0; buf_q.delete();
    end else begin
      if (bus.if_ex_flush) begin
        m_valid = 0; m_instr = NOP; m_mis = 0; buf_q.delete();
      end else if (bus.if_ex_stall) begin
        if (done) buf_q.push_back('{instr: bus.imem_rdata, pc: m_pc});
      end else if (buf_q.size() != 0) begin
        e = buf_q.pop_front();
        m_instr = e.instr; m_fpc = e.pc; m_fpc4 = e.pc + 4; m_valid = 1; m_mis = 0;
      end else if (done) begin
        m_instr = bus.imem_rdata; m_fpc = m_pc; m_fpc4 = m_pc + 4; m_valid = 1; m_mis = 0;
      end else if (MIS && started && m_pc[1:0] != 2'b00) begin
        m_valid = 0; m_instr = NOP; m_fpc = m_pc; m_mis = 1;
      end else begin
        m_valid = 0; m_instr = NOP;
      end
      if (bus.pc_en) m_pc = bus.npc_sel ? bus.brj_addr : m_pc + 4;
      started = 1;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("imem_ren", {31'd0, bus.imem_ren}, {31'd0, m_req()});
      chk("iren", {31'd0, bus.iren}, {31'd0, m_req()});
      chk("i_ram_busy", {31'd0, bus.i_ram_busy}, {31'd0, m_req() & bus.imem_busy});
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, m_valid});
      chk("fetch_instr", bus.fetch_instr, m_instr);
      chk("fetch_pc", bus.fetch_pc, m_fpc);
      chk("fetch_pc4", bus.fetch_pc4, m_fpc4);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("fetch_misaligned", {31'd0, bus.fetch_misaligned}, {31'd0, m_mis});
`endif
    end
  end

  task automatic cyc(input bit r, input bit pe, input bit ns, input bit st, input bit fl,
                     input bit bz, input logic [31:0] brj, input logic [31:0] rd);
    RST = r;
    bus.pc_en = pe;
    bus.npc_sel = ns;
    bus.if_ex_stall = st;
    bus.if_ex_flush = fl;
    bus.imem_busy = bz;
    bus.brj_addr = brj;
    bus.imem_rdata = rd;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset for two cycles.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("rst instr", bus.fetch_instr, 32'h13);
    chk("rst pc", bus.fetch_pc, 32'd0);
    chk("rst pc4", bus.fetch_pc4, 32'd0);
    chk("rst ren", {31'd0, bus.imem_ren}, 32'd0);
    chk("rst addr", bus.imem_addr, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("first ren", {31'd0, bus.imem_ren}, 32'd1);
    chk("first addr", bus.imem_addr, 32'h200);

    // Zero-wait sequential fetch.
    cyc(0, 1, 0, 0, 0, 0, 0, 32'hA);
    chk("seq0 pc", bus.fetch_pc, 32'h200);
    chk("seq0 pc4", bus.fetch_pc4, 32'h204);
    chk("seq0 valid", {31'd0, bus.fetch_valid}, 32'd1);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'hB);
    chk("seq1 pc", bus.fetch_pc, 32'h204);
    chk("seq1 instr", bus.fetch_instr, 32'hB);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'hC);
    chk("seq2 pc4", bus.fetch_pc4, 32'h20C);

    // Three wait states.
    cyc(0, 0, 0, 0, 0, 1, 0, 32'hDEAD);
    chk("busy i_ram_busy", {31'd0, bus.i_ram_busy}, 32'd1);
    chk("busy bubble", {31'd0, bus.fetch_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'hDEAD);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'hDEAD);
    chk("busy hold pc", bus.fetch_pc, 32'h208);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'hD);
    chk("after busy instr", bus.fetch_instr, 32'hD);
    chk("after busy pc", bus.fetch_pc, 32'h20C);

    // Completion under stall goes to the hold buffer.
    cyc(0, 1, 0, 1, 0, 0, 0, 32'hE);
    chk("stall latch held", bus.fetch_instr, 32'hD);
    chk("hold no ren", {31'd0, bus.imem_ren}, 32'd0);
    cyc(0, 0, 0, 1, 0, 0, 0, 32'hBAD);
    chk("hold latch held", bus.fetch_pc, 32'h20C);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hBAD);
    chk("drain instr", bus.fetch_instr, 32'hE);
    chk("drain pc4", bus.fetch_pc4, 32'h214);
    chk("drain next addr", bus.imem_addr, 32'h214);

    // Redirect with flush.
    cyc(0, 1, 1, 0, 1, 0, 32'h400, 32'hF);
    chk("flush valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("redirect addr", bus.imem_addr, 32'h400);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h11);
    chk("target pc", bus.fetch_pc, 32'h400);

    // Flush and stall together while holding.
    cyc(0, 1, 0, 1, 0, 0, 0, 32'h22);
    cyc(0, 0, 0, 1, 1, 0, 0, 32'hBAD);
    chk("flush wins instr", bus.fetch_instr, 32'h13);
    chk("flush refetch ren", {31'd0, bus.imem_ren}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h33);
    chk("buffer dropped", bus.fetch_instr, 32'h33);
    chk("buffer dropped pc", bus.fetch_pc, 32'h408);

    // PC wrap.
    cyc(0, 1, 1, 0, 1, 0, 32'hFFFF_FFFC, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h44);
    chk("wrap pc4", bus.fetch_pc4, 32'd0);
    chk("wrap addr", bus.imem_addr, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h55);
    chk("wrap next pc", bus.fetch_pc, 32'd0);

    // Reset mid-request, then redirect while busy.
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 32'h66);
    chk("mid rst valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("mid rst addr", bus.imem_addr, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 1, 32'h300, 32'hBAD);
    chk("busy redirect addr", bus.imem_addr, 32'h300);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h77);
    chk("busy redirect pc", bus.fetch_pc, 32'h300);
    chk("busy redirect instr", bus.fetch_instr, 32'h77);

`ifdef FETCH_MISALIGN_CHECK_EN
    cyc(0, 1, 1, 0, 1, 0, 32'h402, 0);
    chk("mis no ren", {31'd0, bus.imem_ren}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hBAD);
    chk("mis flag", {31'd0, bus.fetch_misaligned}, 32'd1);
    chk("mis pc", bus.fetch_pc, 32'h402);
    chk("mis valid", {31'd0, bus.fetch_valid}, 32'd0);
    cyc(0, 1, 1, 0, 0, 0, 32'h500, 32'hBAD);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h88);
    chk("mis cleared", {31'd0, bus.fetch_misaligned}, 32'd0);
    chk("mis recover pc", bus.fetch_pc, 32'h500);
`endif

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
